// File: rtl/fpu_arb_pkg.sv
// Shared configuration and tag types for the FPU issue arbiter.
// Every module of the arbiter takes its sizing from here so the widths agree.
package fpu_arb_pkg;
    localparam int N_REQ     = 4;
    localparam int DATA_W    = 32;
    localparam int OP_W      = 4;
    localparam int LATENCY   = 13;
    localparam int MAX_OUTST = 4;
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;
endpackage

// File: rtl/fpu_tag_delay.sv
// Fixed-depth, never-stalling shift register that carries requester IDs
// alongside the FPU pipeline so each result can be steered back to its owner.
module fpu_tag_delay
    import fpu_arb_pkg::*;
#(
    parameter int D = LATENCY + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [ID_W-1:0] id_in,
    output logic            valid_out,
    output logic [ID_W-1:0] id_out,
    output logic            any_valid
);
    tag_t [D-1:0] stage_reg;

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg[gi] <= '0;
                end else if (gi == 0) begin
                    stage_reg[gi] <= '{valid: valid_in, id: id_in};
                end else begin
                    stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < D; i++) begin
            any_valid = any_valid | stage_reg[i].valid;
        end
    end

    assign valid_out = stage_reg[D-1].valid;
    assign id_out    = stage_reg[D-1].id;
endmodule

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency FPU among N_REQ requesters,
// with a per-requester outstanding cap and latency-matched result steering.
module fpu_issue_arbiter
    import fpu_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hold,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*OP_W-1:0]   req_op,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic                    fpu_valid,
    output logic [OP_W-1:0]         fpu_op,
    output logic [DATA_W-1:0]       fpu_a,
    output logic [DATA_W-1:0]       fpu_b,
    input  logic [DATA_W-1:0]       fpu_result,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    busy
);
    logic [N_REQ-1:0][CNT_W-1:0] cnt_reg;
    logic [ID_W-1:0]             ptr_reg;
    logic [N_REQ-1:0]            eligible;
    logic [ID_W-1:0]             winner;
    logic                        grant;
    int                          idx;
    logic                        tag_valid;
    logic [ID_W-1:0]             tag_id;
    logic                        pipe_busy;

    // Retires are not bypassed: a requester at its cap waits one extra cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            logic inc;
            logic dec;

            assign eligible[gi] = rst_n && !hold && req_valid[gi]
                                  && (cnt_reg[gi] < CNT_W'(MAX_OUTST));
            assign inc = grant && (winner == ID_W'(gi));
            assign dec = resp_valid[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (inc && !dec) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end else if (dec && !inc) begin
                    cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        grant  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_reg) + k) % N_REQ;
            if (!grant && eligible[idx]) begin
                grant  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            fpu_valid <= 1'b0;
            fpu_op    <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
        end else begin
            fpu_valid <= grant;
            if (grant) begin
                ptr_reg <= (winner == ID_W'(N_REQ-1)) ? '0 : winner + 1'b1;
                fpu_op  <= req_op[winner*OP_W +: OP_W];
                fpu_a   <= req_a[winner*DATA_W +: DATA_W];
                fpu_b   <= req_b[winner*DATA_W +: DATA_W];
            end
        end
    end

    fpu_tag_delay #(.D(LATENCY + 1)) u_tag_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (grant),
        .id_in     (winner),
        .valid_out (tag_valid),
        .id_out    (tag_id),
        .any_valid (pipe_busy)
    );

    always_comb begin
        resp_valid = '0;
        if (tag_valid) begin
            resp_valid[tag_id] = 1'b1;
        end
    end

    assign resp_data = fpu_result;
    assign busy      = fpu_valid | pipe_busy;
endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Randomised scoreboard bench for fpu_issue_arbiter: a reference model of the
// arbitration rules predicts grants, issues and responses; a monitor checks them.
module tb_fpu_issue_arbiter;
    import fpu_arb_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    hold = 1'b0;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*OP_W-1:0]   req_op = '0;
    logic [N_REQ*DATA_W-1:0] req_a = '0;
    logic [N_REQ*DATA_W-1:0] req_b = '0;
    logic                    fpu_valid;
    logic [OP_W-1:0]         fpu_op;
    logic [DATA_W-1:0]       fpu_a;
    logic [DATA_W-1:0]       fpu_b;
    logic [DATA_W-1:0]       fpu_result = '0;
    logic [N_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]       resp_data;
    logic                    busy;

    fpu_issue_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .fpu_valid  (fpu_valid),
        .fpu_op     (fpu_op),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_result (fpu_result),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              id;
        logic [OP_W-1:0] op;
        logic [31:0]     a;
        logic [31:0]     b;
        int              t;
        int              due;
    } op_t;

    op_t         iss_q[$];
    op_t         rsp_q[$];
    int          due_q[N_REQ][$];
    int          model_ptr = 0;
    int          cyc = 0;
    int          cmp_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] ring_data[64];
    bit          ring_vld[64];

    function automatic logic [31:0] fpu_fn(logic [OP_W-1:0] op, logic [31:0] a, logic [31:0] b);
        return (a + b) ^ {op, 28'h0000001};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // FPU model plus output monitor; outputs are sampled just after the falling edge.
    initial begin
        int slot;
        op_t e;
        forever begin
            @(negedge clk);
            cyc++;
            slot = cyc % 64;
            fpu_result = ring_vld[slot] ? ring_data[slot] : $urandom;
            ring_vld[slot] = 1'b0;
            if (fpu_valid) begin
                ring_data[(cyc + LATENCY) % 64] = fpu_fn(fpu_op, fpu_a, fpu_b);
                ring_vld[(cyc + LATENCY) % 64]  = 1'b1;
            end
            #1;
            check("busy", 64'(busy), 64'(rsp_q.size() > 0));
            if (fpu_valid) begin
                if (iss_q.size() == 0) begin
                    fail_now("unexpected fpu_valid");
                end else begin
                    e = iss_q.pop_front();
                    check("issue_cycle", 64'(cyc), 64'(e.t));
                    check("fpu_op", 64'(fpu_op), 64'(e.op));
                    check("fpu_a", 64'(fpu_a), 64'(e.a));
                    check("fpu_b", 64'(fpu_b), 64'(e.b));
                end
            end else if (iss_q.size() > 0 && iss_q[0].t <= cyc) begin
                void'(iss_q.pop_front());
                fail_now("missing fpu_valid");
            end
            if (resp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected resp_valid");
                end else begin
                    e = rsp_q.pop_front();
                    check("resp_cycle", 64'(cyc), 64'(e.due));
                    check("resp_valid", 64'(resp_valid), 64'(N_REQ'(1) << e.id));
                    check("resp_data", 64'(resp_data), 64'(fpu_fn(e.op, e.a, e.b)));
                    $display("resp  req%0d data %08h cycle %0d", e.id, resp_data, cyc);
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                void'(rsp_q.pop_front());
                fail_now("missing resp_valid");
            end
        end
    end

    // One stimulus cycle: drive inputs, predict the grant from the rules, record the op.
    task automatic step(logic [N_REQ-1:0] v, bit h, bit fixed);
        int win;
        op_t e;
        @(negedge clk);
        #2;
        req_valid = v;
        hold      = h;
        for (int i = 0; i < N_REQ; i++) begin
            req_op[i*OP_W +: OP_W]     = OP_W'($urandom);
            req_a[i*DATA_W +: DATA_W]  = $urandom;
            req_b[i*DATA_W +: DATA_W]  = $urandom;
        end
        if (fixed) begin
            req_op[2*OP_W +: OP_W]    = 4'd3;
            req_a[2*DATA_W +: DATA_W] = 32'h3F80_0000;
            req_b[2*DATA_W +: DATA_W] = 32'h4000_0000;
        end
        #1;
        // An op still counts against its owner up to and including its result cycle.
        for (int i = 0; i < N_REQ; i++) begin
            while (due_q[i].size() > 0 && due_q[i][0] < cyc) void'(due_q[i].pop_front());
        end
        win = -1;
        if (rst_n && !h) begin
            for (int k = 0; k < N_REQ; k++) begin
                int r;
                r = (model_ptr + k) % N_REQ;
                if (win < 0 && v[r] && due_q[r].size() < MAX_OUTST) win = r;
            end
        end
        check("req_ready", 64'(req_ready), (win >= 0) ? 64'(N_REQ'(1) << win) : 64'd0);
        if (win >= 0) begin
            e.id  = win;
            e.op  = req_op[win*OP_W +: OP_W];
            e.a   = req_a[win*DATA_W +: DATA_W];
            e.b   = req_b[win*DATA_W +: DATA_W];
            e.t   = cyc + 1;
            e.due = cyc + 1 + LATENCY;
            iss_q.push_back(e);
            rsp_q.push_back(e);
            due_q[win].push_back(e.due);
            model_ptr = (win + 1) % N_REQ;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_fpu_valid", 64'(fpu_valid), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fpu_op", 64'(fpu_op), 64'd0);
        check("rst_fpu_a", 64'(fpu_a), 64'd0);
        check("rst_fpu_b", 64'(fpu_b), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req_valid = '0;
        hold = 1'b0;
        #1;
        check_reset_outputs();
        iss_q.delete();
        rsp_q.delete();
        for (int i = 0; i < N_REQ; i++) due_q[i].delete();
        model_ptr = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check_reset_outputs();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        step(4'b0100, 1'b0, 1'b1);                       // single op from requester 2
        idle(16);
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b0);  // fairness
        idle(16);
        for (int i = 0; i < 40; i++) step(4'b0010, 1'b0, 1'b0); // outstanding cap
        idle(16);
        step(4'b0001, 1'b0, 1'b0);                       // issue and retire coincide
        idle(13);
        step(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(4'b0001, 1'b0, 1'b0);
        idle(16);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0);  // hold with ops in flight
        for (int i = 0; i < 20; i++) step(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, 1'b0);
        idle(16);
        for (int i = 0; i < 1500; i++) step(N_REQ'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b0);  // reset with ops in flight
        pulse_reset();
        idle(16);
        step(4'b1010, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(N_REQ'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
        idle(20);
        check("final_issue_queue", 64'(iss_q.size()), 64'd0);
        check("final_resp_queue", 64'(rsp_q.size()), 64'd0);
        check("final_busy", 64'(busy), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
